// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned INSTR_W     = 9;
    localparam int unsigned IMEM_AW     = 12;
    localparam int unsigned QUEUE_DEPTH = 2;
    localparam int unsigned OCC_W       = 2;          // holds 0..QUEUE_DEPTH
    localparam int unsigned CNT_W       = OCC_W + 1;  // occ + inflight - pop without overflow

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} pairs toward decode.
//   clk, reset  : clock, asynchronous active-high reset
//   push        : write push_entry at the tail
//   pop         : remove the head (ignored when empty)
//   flush       : empty the queue; overrides push and pop
//   head        : entry at the head register
//   occ         : number of valid entries (0..2)
module fetch_queue
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [OCC_W-1:0] occ
);

    fetch_entry_t     head_q, head_d;
    fetch_entry_t     tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             do_pop;

    // Next-state: the head always holds the oldest entry, the tail the second.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        do_pop = pop && (occ_q != '0);
        if (flush) begin
            occ_d = '0;
        end else if (push && do_pop) begin
            if (occ_q == OCC_W'(2)) begin
                head_d = tail_q;
                tail_d = push_entry;
            end else begin
                head_d = push_entry;
            end
        end else if (do_pop) begin
            head_d = tail_q;
            occ_d  = occ_q - OCC_W'(1);
        end else if (push) begin
            if (occ_q == '0) begin
                head_d = push_entry;
            end else begin
                tail_d = push_entry;
            end
            occ_d = occ_q + OCC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head = head_q;
    assign occ  = occ_q;

    // The issue rule upstream must keep the queue from ever overfilling.
    occ_in_range: assert property (@(posedge clk) disable iff (reset)
        occ_q <= OCC_W'(QUEUE_DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues reads to a synchronous imem, returns next_pc
// to the external PC register, buffers responses toward decode, and handles
// redirects and halt.
//   clk, reset                         : clock, asynchronous active-high reset
//   pc_in / next_pc                    : PC register output / input
//   imem_rd_en, imem_addr, imem_rdata  : instruction memory read port (1-cycle latency)
//   redirect_valid, redirect_pc        : taken branch/jump from execute
//   halt_req                           : halt request from decode
//   out_valid, out_ready, out_instr, out_pc : decode handshake
//   done                               : fetch halted, sticky until reset
module fetch_unit
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_in,
    output logic [PC_W-1:0]    next_pc,
    output logic               imem_rd_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt_req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               done
);

    fetch_state_t     state_q, state_d;
    logic             inflight_q, inflight_d;
    logic             epoch_q, epoch_d;
    logic             tag_q, tag_d;
    logic [PC_W-1:0]  pend_pc_q, pend_pc_d;
    logic             done_q, done_d;

    logic             run, pop, oob, halt_ev, redirect_ev, flush, issue, push;
    logic [CNT_W-1:0] pending;
    logic [OCC_W-1:0] occ;
    fetch_entry_t     head, push_entry;

    // Issue/flush decisions, next-state and PC steering.
    always_comb begin
        state_d    = state_q;
        inflight_d = 1'b0;
        epoch_d    = epoch_q;
        tag_d      = tag_q;
        pend_pc_d  = pend_pc_q;
        done_d     = done_q;
        next_pc    = pc_in;
        imem_rd_en = 1'b0;

        run         = (state_q == RUN);
        pop         = out_valid && out_ready;
        oob         = (pc_in[PC_W-1:IMEM_AW] != '0);
        halt_ev     = run && (halt_req || oob);
        redirect_ev = run && redirect_valid && !halt_ev;
        flush       = halt_ev || redirect_ev;
        // Slots already claimed after this cycle's pop: queued plus in flight.
        pending     = CNT_W'(occ) + CNT_W'(inflight_q) - CNT_W'(pop);
        issue       = run && !redirect_valid && !halt_req && !oob
                      && (pending < CNT_W'(QUEUE_DEPTH));
        // Responses from an older epoch, or landing during a flush, are dropped.
        push        = inflight_q && (tag_q == epoch_q) && !flush;

        if (halt_ev) begin
            state_d = HALTED;
            done_d  = 1'b1;
        end
        if (flush) begin
            epoch_d = !epoch_q;
        end
        if (redirect_ev) begin
            next_pc = redirect_pc;
        end else if (issue) begin
            next_pc    = pc_in + PC_W'(1);
            imem_rd_en = 1'b1;
            inflight_d = 1'b1;
            tag_d      = epoch_q;
            pend_pc_d  = pc_in;
        end

        if (reset) begin
            next_pc    = '0;
            imem_rd_en = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            inflight_q <= 1'b0;
            epoch_q    <= 1'b0;
            tag_q      <= 1'b0;
            pend_pc_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            epoch_q    <= epoch_d;
            tag_q      <= tag_d;
            pend_pc_q  <= pend_pc_d;
            done_q     <= done_d;
        end
    end

    assign push_entry = '{pc: pend_pc_q, instr: imem_rdata};

    fetch_queue u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush),
        .head       (head),
        .occ        (occ)
    );

    assign imem_addr = pc_in[IMEM_AW-1:0];
    assign out_valid = (occ != '0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign done      = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        imem_rd_en;
    logic [11:0] imem_addr;
    logic [8:0]  imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_instr;
    logic [31:0] out_pc;
    logic        done;

    logic [8:0]  mem [0:4095];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // Environment: the PC register and a synchronous instruction memory.
    always @(posedge clk or posedge reset) begin
        if (reset) pc_q <= 32'd0;
        else       pc_q <= next_pc;
    end

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .pc_in          (pc_q),
        .next_pc        (next_pc),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .done           (done)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0;
        out_ready = 1'b1; redirect_pc = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%0b exp=0", imem_rd_en); end
        checks++; if (next_pc !== 32'd0) begin failures++; $display("FAIL reset_next_pc got=%0h exp=0", next_pc); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // PCs 0,1,2,... stream out from cycle 2 with out_ready high.
    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++; if (imem_rd_en !== 1'b1) begin failures++; $display("FAIL stream_rd_en k=%0d got=%0b exp=1", k, imem_rd_en); end
            checks++; if (next_pc !== 32'(k + 1)) begin failures++; $display("FAIL stream_next_pc k=%0d got=%0h exp=%0h", k, next_pc, k + 1); end
            if (k < 2) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid k=%0d got=%0b exp=0", k, out_valid); end
            end else begin
                checks++; if (out_valid !== 1'b1 || out_pc !== 32'(k - 2)) begin failures++; $display("FAIL stream_out_pc k=%0d got=%0b/%0h exp=1/%0h", k, out_valid, out_pc, k - 2); end
                checks++; if (out_instr !== mem[k - 2]) begin failures++; $display("FAIL stream_instr k=%0d got=%0h exp=%0h", k, out_instr, mem[k - 2]); end
            end
            @(negedge clk);
        end
    endtask

    // Back-pressure holds the PC and stops reads; release resumes without gaps.
    task automatic test_stall();
        do_reset();
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            checks++; if (imem_rd_en !== 1'b0) begin failures++; $display("FAIL stall_rd_en j=%0d got=%0b exp=0", j, imem_rd_en); end
            checks++; if (next_pc !== 32'd4) begin failures++; $display("FAIL stall_next_pc j=%0d got=%0h exp=4", j, next_pc); end
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'd2) begin failures++; $display("FAIL stall_head j=%0d got=%0b/%0h exp=1/2", j, out_valid, out_pc); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'(2 + j)) begin failures++; $display("FAIL stall_resume j=%0d got=%0b/%0h exp=1/%0h", j, out_valid, out_pc, 2 + j); end
            @(negedge clk);
        end
    endtask

    // Model: at most two instructions fetched but not yet taken by decode;
    // each becomes visible two cycles after its issue, in PC order.
    task automatic test_random_stream(input int n);
        int          q[$];
        int          cyc;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
        bit          exp_valid, pop, exp_issue;
        do_reset();
        exp_pc = 32'd0;
        cyc    = 0;
        for (int i = 0; i < n; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_valid = (q.size() > 0) && (q[0] <= cyc - 2);
            checks++; if (out_valid !== exp_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, exp_valid); end
            pop       = exp_valid && out_ready;
            exp_issue = (q.size() - int'(pop)) < 2;
            exp_next  = exp_issue ? pc_q + 32'd1 : pc_q;
            checks++; if (imem_rd_en !== exp_issue) begin failures++; $display("FAIL rand_rd_en cyc=%0d got=%0b exp=%0b", cyc, imem_rd_en, exp_issue); end
            checks++; if (next_pc !== exp_next) begin failures++; $display("FAIL rand_next_pc cyc=%0d got=%0h exp=%0h", cyc, next_pc, exp_next); end
            if (pop) begin
                checks++; if (out_pc !== exp_pc || out_instr !== mem[exp_pc[11:0]]) begin failures++; $display("FAIL rand_pop cyc=%0d got=%0h/%0h exp=%0h/%0h", cyc, out_pc, out_instr, exp_pc, mem[exp_pc[11:0]]); end
                exp_pc = exp_pc + 32'd1;
                void'(q.pop_front());
            end
            if (exp_issue) q.push_back(cyc);
            cyc++;
            @(negedge clk);
        end
    endtask

    // Redirect with one entry queued and one read in flight.
    task automatic test_redirect();
        do_reset();
        repeat (5) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1;
        checks++; if (imem_rd_en !== 1'b0 || next_pc !== 32'h40) begin failures++; $display("FAIL redir_cycle got=%0b/%0h exp=0/40", imem_rd_en, next_pc); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'd3) begin failures++; $display("FAIL redir_pop got=%0b/%0h exp=1/3", out_valid, out_pc); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%0b exp=0", out_valid); end
        checks++; if (imem_rd_en !== 1'b1 || next_pc !== 32'h41) begin failures++; $display("FAIL redir_first_issue got=%0b/%0h exp=1/41", imem_rd_en, next_pc); end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_stale got=%0b exp=0", out_valid); end
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'(32'h40 + j) || out_instr !== mem[12'h40 + 12'(j)]) begin failures++; $display("FAIL redir_stream j=%0d got=%0b/%0h exp=1/%0h", j, out_valid, out_pc, 32'h40 + j); end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        bit found = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (pc_q == 32'd7) begin found = 1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin failures++; $display("FAIL halt_reach_pc7 got=%0h exp=7", pc_q); end
        halt_req = 1'b1;
        #1;
        checks++; if (imem_rd_en !== 1'b0 || next_pc !== 32'd7 || done !== 1'b0) begin failures++; $display("FAIL halt_cycle got=%0b/%0h/%0b exp=0/7/0", imem_rd_en, next_pc, done); end
        @(negedge clk);
        halt_req = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80;
        #1;
        checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL halt_done got=%0b/%0b exp=1/0", done, out_valid); end
        checks++; if (next_pc !== 32'd7 || imem_rd_en !== 1'b0) begin failures++; $display("FAIL halt_ignore_redir got=%0h/%0b exp=7/0", next_pc, imem_rd_en); end
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++; if (done !== 1'b1 || out_valid !== 1'b0 || next_pc !== 32'd7) begin failures++; $display("FAIL halt_frozen j=%0d got=%0b/%0b/%0h exp=1/0/7", j, done, out_valid, next_pc); end
            @(negedge clk);
        end
    endtask

    // Halt and redirect together: halt wins and the PC holds.
    task automatic test_halt_vs_redirect();
        logic [31:0] held;
        do_reset();
        repeat (3) @(negedge clk);
        held = pc_q;
        halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        checks++; if (next_pc !== held) begin failures++; $display("FAIL halt_wins_pc got=%0h exp=%0h", next_pc, held); end
        @(negedge clk);
        halt_req = 1'b0; redirect_valid = 1'b0;
        #1;
        checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL halt_wins_done got=%0b/%0b exp=1/0", done, out_valid); end
        @(negedge clk);
    endtask

    // Running off the end of imem halts instead of wrapping the address.
    task automatic test_oob();
        bit          found = 0;
        int          npops = 0;
        logic [31:0] last_pc = 32'hFFFF_FFFF;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFD;
        #1;
        checks++; if (next_pc !== 32'hFFD) begin failures++; $display("FAIL oob_redir got=%0h exp=ffd", next_pc); end
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid) begin npops++; last_pc = out_pc; end
            if (pc_q == 32'h1000) begin
                found = 1;
                checks++; if (imem_rd_en !== 1'b0 || next_pc !== 32'h1000) begin failures++; $display("FAIL oob_no_issue got=%0b/%0h exp=0/1000", imem_rd_en, next_pc); end
                break;
            end
            @(negedge clk);
        end
        checks++; if (!found) begin failures++; $display("FAIL oob_reach got=%0h exp=1000", pc_q); end
        @(negedge clk); #1;
        checks++; if (done !== 1'b1 || out_valid !== 1'b0 || imem_rd_en !== 1'b0) begin failures++; $display("FAIL oob_done got=%0b/%0b/%0b exp=1/0/0", done, out_valid, imem_rd_en); end
        checks++; if (npops != 2 || last_pc !== 32'hFFE) begin failures++; $display("FAIL oob_last_pc got=%0d/%0h exp=2/ffe", npops, last_pc); end
        @(negedge clk);
    endtask

    // Short reset pulse with an entry queued and a read in flight.
    task automatic test_reset_midop();
        do_reset();
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || next_pc !== 32'd0 || imem_rd_en !== 1'b0) begin failures++; $display("FAIL midrst_immediate got=%0b/%0h/%0b exp=0/0/0", out_valid, next_pc, imem_rd_en); end
        #1 reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k < 2) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale k=%0d got=%0b exp=0", k, out_valid); end
            end else begin
                checks++; if (out_valid !== 1'b1 || out_pc !== 32'(k - 2)) begin failures++; $display("FAIL midrst_restart k=%0d got=%0b/%0h exp=1/%0h", k, out_valid, out_pc, k - 2); end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0;
        out_ready = 1'b1; redirect_pc = 32'd0;
        for (int i = 0; i < 4096; i++) mem[i] = 9'($urandom);
        test_reset();
        test_stream();
        test_stall();
        test_random_stream(300);
        test_redirect();
        test_halt();
        test_halt_vs_redirect();
        test_oob();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
